// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_if.sv
// Operand/strobe/result bundle between the execute stage and multdiv_unit.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_addsub.sv
// Combinational adder/subtractor shared by the Booth and restoring-divide steps.
module multdiv_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         co_o
);
    logic [N-1:0] b_x;

    assign b_x = sub_i ? ~b_i : b_i;
    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{N{1'b0}}, sub_i};
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input logic      clock,
    input logic      reset,
    multdiv_if.slave bus
);
    localparam int PW = 2 * WIDTH + 1;

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [PW-1:0]    p_q;
    logic             neg_q;
    logic             dz_q;
    logic             ovf_q;
    logic [WIDTH-1:0] res_q;
    logic             exc_q;
    logic             rdy_q;

    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_b;
    logic [WIDTH:0]   as_s;
    logic             as_sub;
    logic             as_co;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [PW-1:0]    p_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] prod;
    logic             mul_exc;
    logic [WIDTH-1:0] div_res;
    logic             start;

    // p_q holds {hi, lo, booth bit}; in divide mode hi is the
    // partial remainder and lo the dividend shifting into the quotient.
    assign hi = p_q[PW-1 -: WIDTH];
    assign lo = p_q[WIDTH:1];

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign a_mag = bus.data_operandA[WIDTH-1] ?
                   -bus.data_operandA : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ?
                   -bus.data_operandB : bus.data_operandB;

    multdiv_addsub #(.N(WIDTH + 1)) u_addsub (
        .a_i   (as_a),
        .b_i   (as_b),
        .sub_i (as_sub),
        .sum_o (as_s),
        .co_o  (as_co)
    );

    always_comb begin
        as_a   = {hi[WIDTH-1], hi};
        as_b   = {a_q[WIDTH-1], a_q};
        as_sub = p_q[1];
        p_d    = {hi[WIDTH-1], hi, p_q[WIDTH:1]};
        if (state_q == DIV) begin
            as_a   = {hi, lo[WIDTH-1]};
            as_b   = {1'b0, a_q};
            as_sub = 1'b1;
            if (as_co) begin
                p_d = {as_s[WIDTH-1:0], lo[WIDTH-2:0], 1'b1, 1'b0};
            end else begin
                p_d = {hi[WIDTH-2:0], lo[WIDTH-1],
                       lo[WIDTH-2:0], 1'b0, 1'b0};
            end
        end else if (p_q[1] ^ p_q[0]) begin
            p_d = {as_s, p_q[WIDTH:1]};
        end
    end

    assign prod    = p_q[PW-1:1];
    assign mul_exc = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};

    // Divide-by-zero overrides the all-ones quotient the array produces.
    always_comb begin
        div_res = neg_q ? -lo : lo;
        if (dz_q) begin
            div_res = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else if (start) begin
            cnt_q <= '0;
            exc_q <= 1'b0;
            rdy_q <= 1'b0;
            if (bus.ctrl_MULT) begin
                state_q <= MULT;
                a_q     <= bus.data_operandA;
                p_q     <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            end else begin
                state_q <= DIV;
                a_q     <= b_mag;
                p_q     <= {{WIDTH{1'b0}}, a_mag, 1'b0};
                neg_q   <= bus.data_operandA[WIDTH-1] ^
                           bus.data_operandB[WIDTH-1];
                dz_q    <= bus.data_operandB == '0;
                ovf_q   <= (bus.data_operandA ==
                            {1'b1, {(WIDTH-1){1'b0}}}) &&
                           (bus.data_operandB == '1);
            end
        end else begin
            unique case (state_q)
                IDLE: rdy_q <= 1'b0;
                MULT, DIV: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        state_q <= DONE;
                        rdy_q   <= 1'b1;
                        if (state_q == MULT) begin
                            res_q <= prod[WIDTH-1:0];
                            exc_q <= mul_exc;
                        end else begin
                            res_q <= div_res;
                            exc_q <= dz_q | ovf_q;
                        end
                    end else begin
                        p_q   <= p_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    rdy_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit: latency, results, restart, reset.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        @(posedge clk);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    task automatic watch(input int n, output int first, output int pulses,
                         output logic [31:0] res, output logic exc);
        first  = -1;
        pulses = 0;
        res    = '0;
        exc    = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (bus.data_resultRDY) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    res   = bus.data_result;
                    exc   = bus.data_exception;
                end
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee);
        int          first;
        int          pulses;
        logic [31:0] res;
        logic        exc;
        issue(m, d, a, b);
        watch(40, first, pulses, res, exc);
        chk({tag, "_edge"}, first, 33);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_res"}, res, er);
        chk({tag, "_exc"}, {31'b0, exc}, {31'b0, ee});
    endtask

    initial begin
        int          first;
        int          pulses;
        logic [31:0] res;
        logic        exc;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        #12;
        chk("rst_res", bus.data_result, 32'd0);
        chk("rst_exc", {31'b0, bus.data_exception}, 32'd0);
        chk("rst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul7x6", 1, 0, 32'd7, 32'd6, 32'd42, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_res", bus.data_result, 32'd42);
        chk("hold_rdy", {31'b0, bus.data_resultRDY}, 32'd0);

        run_op("mul_m3x5", 1, 0, -32'sd3, 32'd5, 32'hFFFF_FFF1, 0);
        run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1);
        run_op("mul_min", 1, 0, INT_MIN, NEG_ONE, INT_MIN, 1);
        run_op("div100_7", 0, 1, 32'd100, 32'd7, 32'd14, 0);
        run_op("div_m100_7", 0, 1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 0);
        run_op("div_m7_m2", 0, 1, -32'sd7, -32'sd2, 32'd3, 0);
        run_op("div5_0", 0, 1, 32'd5, 32'd0, 32'd0, 1);

        issue(0, 1, INT_MIN, NEG_ONE);
        chk("exc_clear", {31'b0, bus.data_exception}, 32'd0);
        watch(40, first, pulses, res, exc);
        chk("div_ovf_edge", first, 33);
        chk("div_ovf_res", res, INT_MIN);
        chk("div_ovf_exc", {31'b0, exc}, 32'd1);

        issue(0, 1, 32'd9, 32'd3);
        watch(9, first, pulses, res, exc);
        chk("rst_pre_pulses", pulses, 0);
        issue(1, 0, 32'd4, 32'd4);
        watch(45, first, pulses, res, exc);
        chk("restart_edge", first + 10, 43);
        chk("restart_pulses", pulses, 1);
        chk("restart_res", res, 32'd16);

        run_op("both", 1, 1, 32'd2, 32'd3, 32'd6, 0);

        issue(1, 0, 32'd123, 32'd456);
        watch(14, first, pulses, res, exc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res", bus.data_result, 32'd0);
        chk("arst_exc", {31'b0, bus.data_exception}, 32'd0);
        chk("arst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch(40, first, pulses, res, exc);
        chk("arst_pulses", pulses, 0);
        run_op("mul2x2", 1, 0, 32'd2, 32'd2, 32'd4, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
